// File: rtl/mod_multi_square.sv
// mod_multi_square: raises a GF(2^M) element to the power 2^k by repeated
// squaring, applying up to S squarings per clock while the operation runs.
// The field is GF(2^M) with reduction trinomial x^M + x^K + 1, polynomial
// basis, bit i of a vector being the coefficient of x^i.
module mod_multi_square #(
  parameter int M     = 257,
  parameter int K     = 12,
  parameter int S     = 1,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [M-1:0]     din,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [M-1:0]     dout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Largest number of squarings a single RUN cycle may consume.
  localparam logic [CNT_W-1:0] S_CNT = CNT_W'(S);

  logic [1:0]       state_reg, state_next;
  logic [M-1:0]     acc_reg, acc_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic [M-1:0]     acc_step;

  // One full field squaring. The coefficient of x^i moves to x^(2i), giving a
  // product of degree up to 2M-2. Terms at degree j >= M are folded through
  // x^M = x^K + 1, i.e. x^j -> x^(j-M+K) + x^(j-M). Walking j from the top
  // down guarantees that a fold landing at or above M (possible because
  // j-M+K can still exceed M-1) is itself folded later in the same walk, so
  // the result always has degree < M. Everything reduces to XOR gates.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    logic [2*M-2:0] t;
    t = '0;
    for (int i = 0; i < M; i++) begin
      t[2*i] = a[i];
    end
    for (int j = 2*M-2; j >= M; j--) begin
      t[j-M+K] = t[j-M+K] ^ t[j];
      t[j-M]   = t[j-M]   ^ t[j];
      t[j]     = 1'b0;
    end
    return t[M-1:0];
  endfunction

  // Chain of S squarers; the tap taken is min(S, rem) squarings deep so the
  // final RUN cycle never overshoots the requested count.
  always_comb begin
    logic [M-1:0] sq_chain;
    sq_chain = acc_reg;
    acc_step = acc_reg;
    for (int i = 1; i <= S; i++) begin
      sq_chain = gf_sq(sq_chain);
      if (rem_reg >= CNT_W'(i)) begin
        acc_step = sq_chain;
      end
    end
  end

  // Next-state logic: starts are taken only when not running; RUN consumes
  // up to S squarings per cycle and exits to DONE once the count is used up.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    rem_next   = rem_reg;
    case (state_reg)
      ST_RUN: begin
        acc_next = acc_step;
        if (rem_reg <= S_CNT) begin
          rem_next   = '0;
          state_next = ST_DONE;
        end else begin
          rem_next = rem_reg - S_CNT;
        end
      end
      default: begin
        // IDLE and DONE behave alike: a start loads a fresh operand, and with
        // no start the machine rests in IDLE while acc keeps the last result.
        if (start) begin
          acc_next   = din;
          rem_next   = count;
          state_next = (count == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous reset that also overrides a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      rem_reg   <= rem_next;
    end
  end

  // acc is only rewritten by RUN or by an accepted start, so it holds the
  // result from the done pulse until the next operation begins.
  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);
  assign dout = acc_reg;

endmodule

// File: doc/mod_multi_square.md
MOD_MULTI_SQUARE -- requirements
Module: mod_multi_square

Interface
REQ-001 SHALL have parameter M, default 257: field degree; field is GF(2^M) with reduction trinomial x^M + x^K + 1.
REQ-002 SHALL have parameter K, default 12: middle trinomial exponent; legal range 1 <= K < M/2.
REQ-003 SHALL have parameter S, default 1: squarings applied per RUN cycle; legal range 1..4.
REQ-004 SHALL have parameter CNT_W, default 9: width of the squaring-count input.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1: request to begin an operation.
REQ-008 SHALL have port din, input, M: operand a, polynomial basis, bit i is the coefficient of x^i.
REQ-009 SHALL have port count, input, CNT_W: number of squarings k.
REQ-010 SHALL have port busy, output, 1: high while squarings are in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse marking dout valid.
REQ-012 SHALL have port dout, output, M: result a^(2^k) mod (x^M + x^K + 1).

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; busy = (state == RUN); done = (state == DONE).
REQ-014 SHALL accept start only in IDLE or DONE; at that edge: acc <= din, rem <= count, state <= DONE if count == 0, else RUN.
REQ-015 SHALL ignore start while in RUN; the operation in flight and its operands SHALL NOT be disturbed.
REQ-016 SHALL, on each RUN cycle, apply n = min(S, rem) squarings to acc and set rem <= rem - n; when rem - n == 0, state <= DONE.
REQ-017 SHALL fully reduce every single squaring to degree < M, including the second fold needed when a folded term lands at degree >= M; e.g. M=257, K=12: x^258 -> x^13 + x.
REQ-018 SHALL compute squaring as bit spreading (a_i -> x^(2i)) plus trinomial folding, as pure XOR logic; no multiplier.
REQ-019 SHALL assert done for exactly one cycle with dout = final acc; latency from the start-accept edge to done high SHALL be 1 + ceil(k/S) cycles (1 cycle when k = 0).
REQ-020 SHALL move from DONE to IDLE when no start is present; a start in DONE begins a new operation, so done pulses can occur back-to-back.
REQ-021 SHALL hold dout stable from done until the next accepted start; dout is don't-care while busy.
REQ-022 SHALL treat count as unsigned; k >= M is legal, and k = M SHALL return din, since a^(2^M) = a in GF(2^M).

Reset
REQ-023 SHALL, on rst high at a clock edge, set state = IDLE, busy = 0, done = 0, dout = 0, acc = 0 and rem = 0, overriding a start in the same cycle.
REQ-024 SHALL, on rst asserted mid-RUN, abort the operation with no done pulse; the first start after rst deasserts is accepted normally.

Verification
REQ-025 Scenario: M=257, K=12, S=1, din = bit129, count=1 -> done 2 cycles after start, dout = bits {1,13} only.
REQ-026 Scenario: S=1, din = bit128, count=1 -> dout = bit256; then din = 1, count=5 -> dout = 1, done 6 cycles after start.
REQ-027 Scenario: 1000 random din, count=257, S in {1,4} -> dout == din; latency 258 cycles (S=1) or 66 cycles (S=4); outputs checked bit-exact against a software GF(2^257) model.
REQ-028 Scenario: count=0 -> done the next cycle with dout = din, busy never high; and start held high through a whole RUN -> only the first start accepted, one done pulse, then an immediate new operation.
REQ-029 Scenario: rst asserted at cycle 3 of a count=10 run -> busy=0, done=0 and dout=0 the next cycle, no done pulse; a following start with count=2 completes with the correct value.
